// File: rtl/id_ex_hazard_ctrl.sv
// rtl/id_ex_hazard_ctrl.sv - ID/EX bubble/hold sequencing for load-use, mult/div, branch and CP0 flushes
module id_ex_hazard_ctrl #(
    parameter int MD_LAT    = 32,
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_ra,
    input  logic [4:0]       id_rb,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regWr,
    input  logic [1:0]       ex_memtoreg,
    input  logic             id_md_start,
    input  logic             ex_br_taken,
    input  logic             ex_cp0_trap,
    input  logic             stall_clr,
    output logic             hazard,
    output logic             BranchBubble,
    output logic [1:0]       cp0bubble,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int MAXL = (MD_LAT > FLUSH_LEN) ? MD_LAT : FLUSH_LEN;
    localparam int CW   = $clog2(MAXL);

    typedef enum logic [1:0] {IDLE, MD_WAIT, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             load_use;

    assign load_use = ex_regWr && (ex_memtoreg == 2'd1) && (ex_rw != 5'd0) &&
                      ((id_use_ra && (id_ra == ex_rw)) || (id_use_rb && (id_rb == ex_rw)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hazard       = 1'b0;
        BranchBubble = 1'b0;
        cp0bubble    = 2'd0;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        md_busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_cp0_trap) begin
                    BranchBubble = 1'b1;
                    cp0bubble    = 2'd1;
                    state_d      = FLUSH;
                    cnt_d        = CW'(FLUSH_LEN - 1);
                end else if (ex_br_taken) begin
                    BranchBubble = 1'b1;
                    state_d      = FLUSH;
                    cnt_d        = CW'(FLUSH_LEN - 1);
                end else if (id_md_start) begin
                    hazard    = 1'b1;
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    md_busy   = 1'b1;
                    state_d   = MD_WAIT;
                    cnt_d     = CW'(MD_LAT - 2);
                end else if (load_use) begin
                    hazard    = 1'b1;
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                // A trap abandons the mult/div; EX holds a bubble so branches cannot occur here
                if (ex_cp0_trap) begin
                    BranchBubble = 1'b1;
                    cp0bubble    = 2'd1;
                    state_d      = FLUSH;
                    cnt_d        = CW'(FLUSH_LEN - 1);
                end else begin
                    hazard    = 1'b1;
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            FLUSH: begin
                BranchBubble = 1'b1;
                if (ex_cp0_trap) begin
                    cp0bubble = 2'd1;
                    cnt_d     = CW'(FLUSH_LEN - 1);
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (stall_clr)                                  stall_d = '0;
        else if ((hazard || BranchBubble) && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb/tb_id_ex_hazard_ctrl.sv - directed vector bench for id_ex_hazard_ctrl
module tb_id_ex_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_ra, id_rb, ex_rw;
    logic       id_use_ra, id_use_rb, ex_regWr;
    logic [1:0] ex_memtoreg;
    logic       id_md_start, ex_br_taken, ex_cp0_trap, stall_clr;
    logic       hazard, BranchBubble, pc_hold, ifid_hold, md_busy;
    logic [1:0] cp0bubble;
    logic [3:0] stall_cycles;

    int n_vec = 0;
    int n_bad = 0;

    id_ex_hazard_ctrl #(.MD_LAT(4), .FLUSH_LEN(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_ra(id_ra), .id_rb(id_rb),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .ex_rw(ex_rw),
        .ex_regWr(ex_regWr), .ex_memtoreg(ex_memtoreg), .id_md_start(id_md_start),
        .ex_br_taken(ex_br_taken), .ex_cp0_trap(ex_cp0_trap), .stall_clr(stall_clr),
        .hazard(hazard), .BranchBubble(BranchBubble), .cp0bubble(cp0bubble),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .md_busy(md_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ra, rb, rw;
        logic       use_ra, use_rb, regwr;
        logic [1:0] m2r;
        logic       md, br, trap;
        logic       e_haz, e_bb;
        logic [1:0] e_cp0;
        logic       e_pc, e_ifid, e_md;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] ra, rb, rw, input logic use_ra, use_rb, regwr,
                                input logic [1:0] m2r, input logic md, br, trap,
                                input logic e_haz, e_bb, input logic [1:0] e_cp0,
                                input logic e_pc, e_ifid, e_md);
        vec_t v;
        v.ra = ra; v.rb = rb; v.rw = rw; v.use_ra = use_ra; v.use_rb = use_rb;
        v.regwr = regwr; v.m2r = m2r; v.md = md; v.br = br; v.trap = trap;
        v.e_haz = e_haz; v.e_bb = e_bb; v.e_cp0 = e_cp0; v.e_pc = e_pc;
        v.e_ifid = e_ifid; v.e_md = e_md;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_ra = 0; id_rb = 0; ex_rw = 0; id_use_ra = 0; id_use_rb = 0;
        ex_regWr = 0; ex_memtoreg = 0; id_md_start = 0; ex_br_taken = 0;
        ex_cp0_trap = 0; stall_clr = 0;
    endtask

    task automatic set_load_use();
        ex_regWr = 1; ex_memtoreg = 2'd1; ex_rw = 5'd5; id_ra = 5'd5; id_use_ra = 1;
    endtask

    task automatic do_clr();
        stall_clr = 1;
        step();
        stall_clr = 0;
    endtask

    initial begin
        //              ra rb rw ura urb wr m2r md br tr  haz bb cp0 pc ifid md
        vecs[0]  = mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(5, 0, 5, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 7, 7, 0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0);
        vecs[4]  = mk(5, 0, 5, 1, 0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(5, 0, 5, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 1, 1, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0);
        vecs[10] = mk(5, 0, 5, 1, 0, 1, 1, 1, 1, 1,  0, 1, 1, 0, 0, 0);
        vecs[11] = mk(5, 0, 5, 1, 0, 1, 1, 1, 0, 0,  1, 0, 0, 1, 1, 1);
        vecs[12] = mk(5, 9, 9, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        clear_in();
        rst_n = 0;
        #12;
        chk("rst_hazard", hazard, 0);
        chk("rst_bb", BranchBubble, 0);
        chk("rst_cp0", cp0bubble, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        rst_n = 1;
        step();

        for (int i = 0; i < 13; i++) begin
            id_ra = vecs[i].ra; id_rb = vecs[i].rb; ex_rw = vecs[i].rw;
            id_use_ra = vecs[i].use_ra; id_use_rb = vecs[i].use_rb;
            ex_regWr = vecs[i].regwr; ex_memtoreg = vecs[i].m2r;
            id_md_start = vecs[i].md; ex_br_taken = vecs[i].br; ex_cp0_trap = vecs[i].trap;
            #1;
            chk($sformatf("v%0d_hazard", i), hazard, vecs[i].e_haz);
            chk($sformatf("v%0d_bb", i), BranchBubble, vecs[i].e_bb);
            chk($sformatf("v%0d_cp0", i), cp0bubble, vecs[i].e_cp0);
            chk($sformatf("v%0d_pc_hold", i), pc_hold, vecs[i].e_pc);
            chk($sformatf("v%0d_ifid_hold", i), ifid_hold, vecs[i].e_ifid);
            chk($sformatf("v%0d_md_busy", i), md_busy, vecs[i].e_md);
            step();
            clear_in();
            repeat (6) step();
        end

        // single load-use stall counted once
        do_clr();
        set_load_use();
        #1;
        chk("lu_hazard", hazard, 1);
        step();
        clear_in();
        #1;
        chk("lu_hazard_after", hazard, 0);
        step();
        chk("lu_stall_cycles", stall_cycles, 1);

        // mult/div occupancy of exactly MD_LAT cycles
        do_clr();
        id_md_start = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("md_busy_c%0d", i), md_busy, (i < 4) ? 1 : 0);
            chk($sformatf("md_hazard_c%0d", i), hazard, (i < 4) ? 1 : 0);
            step();
            id_md_start = 0;
        end
        chk("md_stall_cycles", stall_cycles, 4);

        // branch beats mult/div in the same cycle
        ex_br_taken = 1; id_md_start = 1;
        #1;
        chk("brmd_bb_c0", BranchBubble, 1);
        chk("brmd_md_c0", md_busy, 0);
        step();
        clear_in();
        #1;
        chk("brmd_bb_flush", BranchBubble, 1);
        chk("brmd_md_flush", md_busy, 0);
        step();
        #1;
        chk("brmd_bb_idle", BranchBubble, 0);
        chk("brmd_md_idle", md_busy, 0);
        repeat (2) step();

        // trap in the second MD_WAIT cycle
        id_md_start = 1;
        step();
        id_md_start = 0;
        step();
        ex_cp0_trap = 1;
        #1;
        chk("mdtrap_cp0", cp0bubble, 1);
        chk("mdtrap_bb", BranchBubble, 1);
        chk("mdtrap_pc_hold", pc_hold, 0);
        step();
        ex_cp0_trap = 0;
        #1;
        chk("mdtrap_md_next", md_busy, 0);
        chk("mdtrap_bb_next", BranchBubble, 1);
        chk("mdtrap_cp0_next", cp0bubble, 0);
        step();
        #1;
        chk("mdtrap_bb_idle", BranchBubble, 0);
        chk("mdtrap_haz_idle", hazard, 0);
        repeat (2) step();

        // FLUSH: trap restarts, branch ignored
        ex_br_taken = 1;
        step();
        ex_br_taken = 0; ex_cp0_trap = 1;
        #1;
        chk("flush_trap_cp0", cp0bubble, 1);
        chk("flush_trap_bb", BranchBubble, 1);
        step();
        ex_cp0_trap = 0; ex_br_taken = 1;
        #1;
        chk("flush_restart_bb", BranchBubble, 1);
        chk("flush_restart_cp0", cp0bubble, 0);
        step();
        ex_br_taken = 0;
        #1;
        chk("flush_br_ignored", BranchBubble, 0);
        repeat (2) step();

        // async reset mid-MD_WAIT
        id_md_start = 1;
        step();
        id_md_start = 0;
        step();
        rst_n = 0;
        #1;
        chk("arst_md_busy", md_busy, 0);
        chk("arst_hazard", hazard, 0);
        chk("arst_pc_hold", pc_hold, 0);
        chk("arst_stall_cycles", stall_cycles, 0);
        #1;
        rst_n = 1;
        step();
        #1;
        chk("arst_idle_md", md_busy, 0);

        // saturation and clear priority
        do_clr();
        set_load_use();
        repeat (20) step();
        chk("sat_stall_cycles", stall_cycles, 15);
        stall_clr = 1;
        step();
        chk("clr_wins", stall_cycles, 0);
        clear_in();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
